wishbone_bus_decoder: RTL and testbench

//  Parametrised single-master, N-slave Wishbone classic interconnect. Replaces hand-wired
//  one-slave-at-a-time hookup in top-level demos: decodes slave index from address bits,

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_watchdog.sv | 27 ++
 rtl/wishbone_bus_decoder.sv | 151 +++++++++++++++
 tb/tb_wishbone_bus_decoder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared state encoding and default widths for the wishbone interconnect
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - clear/enable cycle counter that flags expiry at TIMEOUT-1
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Expiry is reported on the final permitted cycle so the owner can act on the same edge.
  assign expire = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wishbone_bus_decoder.sv
// rtl/wishbone_bus_decoder.sv - single-master, N-slave wishbone classic decoder with timeout error
module wishbone_bus_decoder
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int DATA_W     = WB_DATA_W,
  parameter int SEL_LSB    = 28,
  parameter int SEL_W      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic                         m_we_i,
  input  logic [DATA_W-1:0]            m_data_i,
  input  logic                         m_cyc_i,
  input  logic                         m_stb_i,
  output logic [DATA_W-1:0]            m_data_o,
  output logic                         m_ack_o,
  output logic                         m_err_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic                         s_we_o,
  output logic [DATA_W-1:0]            s_data_o,
  output logic [NUM_SLAVES-1:0]        s_cyc_o,
  output logic [NUM_SLAVES-1:0]        s_stb_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i,
  output logic                         busy_o,
  output logic [15:0]                  err_count_o
);

  wb_state_e              state_q, state_d;
  logic [SEL_W-1:0]       req_idx, idx_q;
  logic                   req_valid;
  logic                   we_q;
  logic [NUM_SLAVES-1:0]  sel_onehot;
  logic [DATA_W-1:0]      rd_data;
  logic                   ack_hit;
  logic                   active;
  logic                   latch_req, ack_set, err_set, data_load;
  logic                   wd_clear, wd_enable, wd_expire;

  assign req_idx   = m_addr_i[SEL_LSB +: SEL_W];
  assign req_valid = (int'(req_idx) < NUM_SLAVES);

  assign s_addr_o = m_addr_i;
  assign s_we_o   = m_we_i;
  assign s_data_o = m_data_i;

  // One-hot decode of the latched index plus the matching read-data mux.
  always_comb begin
    sel_onehot = '0;
    rd_data    = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      sel_onehot[k] = (int'(idx_q) == k);
      rd_data = rd_data | (s_data_i[k*DATA_W +: DATA_W] & {DATA_W{sel_onehot[k]}});
    end
  end

  assign ack_hit = |(s_ack_i & sel_onehot);
  assign active  = (state_q == ST_ACTIVE);

  // Strobes follow m_cyc_i combinationally so an aborting master releases the slave at once.
  assign s_cyc_o = (active && m_cyc_i) ? sel_onehot : '0;
  assign s_stb_o = (active && m_cyc_i) ? sel_onehot : '0;

  assign busy_o = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    ack_set   = 1'b0;
    err_set   = 1'b0;
    data_load = 1'b0;
    wd_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          latch_req = 1'b1;
          if (req_valid) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_RESP;
            err_set = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        // Abort beats ack, and ack beats timeout on the same edge.
        if (!m_cyc_i) begin
          state_d = ST_IDLE;
        end else if (ack_hit) begin
          state_d   = ST_RESP;
          ack_set   = 1'b1;
          data_load = !we_q;
        end else if (wd_expire) begin
          state_d = ST_RESP;
          err_set = 1'b1;
        end else begin
          wd_enable = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wd_clear = !active;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (wd_clear),
    .enable    (wd_enable),
    .expire    (wd_expire)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      we_q        <= 1'b0;
      m_data_o    <= '0;
      m_ack_o     <= 1'b0;
      m_err_o     <= 1'b0;
      err_count_o <= 16'd0;
    end else begin
      state_q <= state_d;
      m_ack_o <= ack_set;
      m_err_o <= err_set;
      if (latch_req) begin
        idx_q <= req_idx;
        we_q  <= m_we_i;
      end
      if (data_load) begin
        m_data_o <= rd_data;
      end
      if (err_set && (err_count_o != 16'hFFFF)) begin
        err_count_o <= err_count_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_bus_decoder.sv
// tb/tb_wishbone_bus_decoder.sv - self-checking bench for wishbone_bus_decoder
module tb_wishbone_bus_decoder;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [AW-1:0]     m_addr_i;
  logic              m_we_i;
  logic [DW-1:0]     m_data_i;
  logic              m_cyc_i;
  logic              m_stb_i;
  logic [DW-1:0]     m_data_o;
  logic              m_ack_o;
  logic              m_err_o;
  logic [AW-1:0]     s_addr_o;
  logic              s_we_o;
  logic [DW-1:0]     s_data_o;
  logic [NS-1:0]     s_cyc_o;
  logic [NS-1:0]     s_stb_o;
  logic [NS*DW-1:0]  s_data_i;
  logic [NS-1:0]     s_ack_i;
  logic              busy_o;
  logic [15:0]       err_count_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_data;
  logic [15:0]   exp_err;

  wishbone_bus_decoder #(
    .NUM_SLAVES (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .SEL_LSB    (28),
    .SEL_W      (4),
    .TIMEOUT    (TO)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .m_addr_i    (m_addr_i),
    .m_we_i      (m_we_i),
    .m_data_i    (m_data_i),
    .m_cyc_i     (m_cyc_i),
    .m_stb_i     (m_stb_i),
    .m_data_o    (m_data_o),
    .m_ack_o     (m_ack_o),
    .m_err_o     (m_err_o),
    .s_addr_o    (s_addr_o),
    .s_we_o      (s_we_o),
    .s_data_o    (s_data_o),
    .s_cyc_o     (s_cyc_o),
    .s_stb_o     (s_stb_o),
    .s_data_i    (s_data_i),
    .s_ack_i     (s_ack_i),
    .busy_o      (busy_o),
    .err_count_o (err_count_o)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  // One complete master transaction against an idealised slave; ack_at >= TO means never ack.
  task automatic run_txn(input logic [3:0] idx, input logic we, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rdata, input int ack_at, input logic noise,
                         input string name);
    logic [NS-1:0] oh;
    logic          acked;
    logic [AW-1:0] addr;
    acked = 1'b0;
    addr  = {idx, 28'($urandom)};
    m_addr_i = addr;
    m_we_i   = we;
    m_data_i = wdata;
    m_cyc_i  = 1'b1;
    m_stb_i  = 1'b1;
    s_ack_i  = '0;
    tick;
    if (int'(idx) >= NS) begin
      exp_err = sat_inc(exp_err);
      checks++;
      if (s_stb_o !== '0 || s_cyc_o !== '0)
        $display("FAIL %s bad_idx_stb: got %b/%b want 0", name, s_cyc_o, s_stb_o);
      if (s_stb_o !== '0 || s_cyc_o !== '0) errors++;
      checks++;
      if (m_err_o !== 1'b1 || m_ack_o !== 1'b0) begin
        $display("FAIL %s bad_idx_resp: got err=%b ack=%b want err=1 ack=0", name, m_err_o, m_ack_o);
        errors++;
      end
    end else begin
      oh = NS'(1) << idx;
      for (int c = 0; c < TO && !acked; c++) begin
        checks++;
        if (s_stb_o !== oh || s_cyc_o !== oh || busy_o !== 1'b1) begin
          $display("FAIL %s strobe_c%0d: got cyc=%b stb=%b busy=%b want %b busy=1",
                   name, c, s_cyc_o, s_stb_o, busy_o, oh);
          errors++;
        end
        checks++;
        if (m_ack_o !== 1'b0 || m_err_o !== 1'b0) begin
          $display("FAIL %s early_resp_c%0d: got ack=%b err=%b want 0", name, c, m_ack_o, m_err_o);
          errors++;
        end
        if (c == 0) begin
          checks++;
          if (s_addr_o !== addr || s_we_o !== we || s_data_o !== wdata) begin
            $display("FAIL %s broadcast: got %h/%b/%h want %h/%b/%h",
                     name, s_addr_o, s_we_o, s_data_o, addr, we, wdata);
            errors++;
          end
        end
        s_data_i = {$urandom, $urandom, $urandom, $urandom};
        s_ack_i  = noise ? (NS'($urandom) & ~oh) : '0;
        if (c == ack_at) begin
          s_ack_i[idx]           = 1'b1;
          s_data_i[idx*DW +: DW] = rdata;
          acked                  = 1'b1;
        end
        tick;
        s_ack_i = '0;
      end
      if (acked && !we) exp_data = rdata;
      if (!acked) exp_err = sat_inc(exp_err);
      checks++;
      if (m_ack_o !== acked || m_err_o !== !acked) begin
        $display("FAIL %s resp: got ack=%b err=%b want ack=%b err=%b",
                 name, m_ack_o, m_err_o, acked, !acked);
        errors++;
      end
      checks++;
      if (s_stb_o !== '0 || s_cyc_o !== '0) begin
        $display("FAIL %s resp_stb: got %b/%b want 0", name, s_cyc_o, s_stb_o);
        errors++;
      end
    end
    checks++;
    if (m_data_o !== exp_data) begin
      $display("FAIL %s data: got %h want %h", name, m_data_o, exp_data);
      errors++;
    end
    checks++;
    if (err_count_o !== exp_err) begin
      $display("FAIL %s err_count: got %h want %h", name, err_count_o, exp_err);
      errors++;
    end
    checks++;
    if (busy_o !== 1'b1) begin
      $display("FAIL %s resp_busy: got %b want 1", name, busy_o);
      errors++;
    end
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    tick;
    checks++;
    if (busy_o !== 1'b0 || m_ack_o !== 1'b0 || m_err_o !== 1'b0) begin
      $display("FAIL %s after_resp: got busy=%b ack=%b err=%b want 0", name, busy_o, m_ack_o, m_err_o);
      errors++;
    end
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    m_addr_i  = '0;
    m_we_i    = 1'b0;
    m_data_i  = '0;
    m_cyc_i   = 1'b0;
    m_stb_i   = 1'b0;
    s_data_i  = '0;
    s_ack_i   = '0;
    tick;
    tick;
    checks++;
    if (m_data_o !== '0 || m_ack_o !== 1'b0 || m_err_o !== 1'b0 || s_cyc_o !== '0 ||
        s_stb_o !== '0 || busy_o !== 1'b0 || err_count_o !== 16'd0) begin
      $display("FAIL reset: got data=%h ack=%b err=%b cyc=%b stb=%b busy=%b cnt=%h want all 0",
               m_data_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, busy_o, err_count_o);
      errors++;
    end
    sys_rst_n = 1'b1;
    exp_data  = '0;
    exp_err   = 16'd0;
    tick;
  endtask

  task automatic test_write;
    run_txn(4'd1, 1'b1, 32'h0000_00A5, 32'h1234_5678, 3, 1'b0, "write_slave1");
  endtask

  task automatic test_read;
    run_txn(4'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, "read_slave2");
  endtask

  task automatic test_bad_index;
    run_txn(4'd5, 1'b0, 32'h0, 32'h0, TO, 1'b0, "bad_index5");
    run_txn(4'd15, 1'b1, 32'h77, 32'h0, TO, 1'b0, "bad_index15");
  endtask

  task automatic test_timeout;
    run_txn(4'd3, 1'b0, 32'h0, 32'h0, TO + 4, 1'b0, "timeout_slave3");
    run_txn(4'd3, 1'b0, 32'h0, 32'hCAFE_F00D, TO - 1, 1'b0, "ack_last_cycle");
  endtask

  task automatic test_abort;
    m_addr_i = 32'h1000_0000;
    m_we_i   = 1'b0;
    m_cyc_i  = 1'b1;
    m_stb_i  = 1'b1;
    tick;
    checks++;
    if (s_stb_o !== 4'b0010) begin
      $display("FAIL abort_first_cycle: got %b want 0010", s_stb_o);
      errors++;
    end
    tick;
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    #1;
    checks++;
    if (s_cyc_o !== '0 || s_stb_o !== '0 || busy_o !== 1'b1) begin
      $display("FAIL abort_drop: got cyc=%b stb=%b busy=%b want 0/0/1", s_cyc_o, s_stb_o, busy_o);
      errors++;
    end
    tick;
    checks++;
    if (busy_o !== 1'b0 || m_ack_o !== 1'b0 || m_err_o !== 1'b0) begin
      $display("FAIL abort_idle: got busy=%b ack=%b err=%b want 0", busy_o, m_ack_o, m_err_o);
      errors++;
    end
    s_ack_i            = 4'b0010;
    s_data_i[DW +: DW] = 32'h0BAD_0BAD;
    tick;
    s_ack_i = '0;
    tick;
    checks++;
    if (m_ack_o !== 1'b0 || m_data_o !== exp_data || err_count_o !== exp_err || busy_o !== 1'b0) begin
      $display("FAIL abort_late_ack: got ack=%b data=%h cnt=%h busy=%b want 0/%h/%h/0",
               m_ack_o, m_data_o, err_count_o, busy_o, exp_data, exp_err);
      errors++;
    end
  endtask

  task automatic test_random;
    logic [3:0] idx;
    for (int n = 0; n < 40; n++) begin
      idx = 4'($urandom_range(0, 6));
      run_txn(idx, 1'($urandom), $urandom, $urandom, int'($urandom_range(0, TO + 3)),
              1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid;
    m_addr_i = 32'h2000_0000;
    m_we_i   = 1'b0;
    m_cyc_i  = 1'b1;
    m_stb_i  = 1'b1;
    tick;
    tick;
    checks++;
    if (busy_o !== 1'b1) begin
      $display("FAIL mid_reset_pre: got busy=%b want 1", busy_o);
      errors++;
    end
    sys_rst_n = 1'b0;
    tick;
    sys_rst_n = 1'b1;
    exp_data  = '0;
    exp_err   = 16'd0;
    checks++;
    if (m_data_o !== '0 || m_ack_o !== 1'b0 || m_err_o !== 1'b0 || s_cyc_o !== '0 ||
        s_stb_o !== '0 || busy_o !== 1'b0 || err_count_o !== 16'd0) begin
      $display("FAIL mid_reset: got data=%h ack=%b err=%b cyc=%b stb=%b busy=%b cnt=%h want all 0",
               m_data_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, busy_o, err_count_o);
      errors++;
    end
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    tick;
  endtask

  task automatic test_saturate;
    force dut.err_count_o = 16'hFFFD;
    #1;
    release dut.err_count_o;
    #1;
    exp_err = 16'hFFFD;
    checks++;
    if (err_count_o !== exp_err) begin
      $display("FAIL sat_preload: got %h want %h", err_count_o, exp_err);
      errors++;
    end
    run_txn(4'd6, 1'b0, 32'h0, 32'h0, TO, 1'b0, "sat_fffe");
    run_txn(4'd7, 1'b0, 32'h0, 32'h0, TO, 1'b0, "sat_ffff");
    run_txn(4'd8, 1'b0, 32'h0, 32'h0, TO, 1'b0, "sat_hold");
    run_txn(4'd0, 1'b0, 32'h0, 32'h0, TO, 1'b0, "sat_timeout");
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_bad_index;
    test_timeout;
    test_abort;
    test_random;
    test_reset_mid;
    test_saturate;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
